// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage feeding the immediate generator / decode.
// Holds the fetch PC and issues one word request at a time to instruction
// memory. Returned words are queued with their PC in a small FIFO and handed
// downstream. A redirect flushes the FIFO and discards any in-flight response.
//
// Optional build macro IFETCH_MISALIGN_CHK_EN: adds the fetch_misalign output.
// A misaligned redirect target then sets a sticky flag and parks the fetcher.
// Without the macro, redirect_pc[1:0] are ignored (forced to zero).
//
// Handshake semantics (all channels): a transfer happens on a rising edge where
// valid and ready are both high. Once imem_req_valid is raised, it and
// imem_req_addr stay stable until the transfer or a redirect. The response
// channel is valid-only: imem_rsp_valid for one cycle carries one word, in
// request order, at least one cycle after the request transfer.
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
`ifdef IFETCH_MISALIGN_CHK_EN
  output logic        fetch_misalign,
`endif
  output logic [1:0]  dbg_state_o
);

  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  // S_REQ: no request outstanding, may issue one.
  // S_RSP: one live request outstanding; its word will be queued.
  // S_FLUSH: one request outstanding whose word must be discarded.
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_RSP   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   buf_data_q [BUF_DEPTH];
  logic [31:0]   buf_pc_q   [BUF_DEPTH];

  logic req_fire;
  logic push;
  logic pop;
  logic parked;

`ifdef IFETCH_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;
  logic redir_misaligned;

  assign redir_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // Sticky misalignment flag: set by a misaligned redirect, cleared by reset.
  always_comb begin
    misalign_d = misalign_q | redir_misaligned;
  end

  // Misalignment flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign parked         = misalign_q;
  assign fetch_misalign = misalign_q;
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign parked              = 1'b0;
`endif

  // Credit rule: only S_REQ has nothing outstanding, so buffered words alone
  // must leave room for the word this request will return.
  assign imem_req_valid = !rst && !parked && (state_q == S_REQ) && (count_q < DEPTH_C);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Downstream view of the FIFO head; a redirect cancels the pop this cycle.
  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? buf_data_q[rd_ptr_q] : NOP;
  assign inst_pc    = inst_valid ? buf_pc_q[rd_ptr_q] : 32'h0000_0000;
  assign pop        = inst_valid && inst_ready && !redirect_valid;

  assign dbg_state_o = state_q;

  // Fetch FSM next state, fetch PC and push decision; redirect overrides all.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;

    case (state_q)
      S_REQ: begin
        if (req_fire) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = S_RSP;
        end
      end
      S_RSP: begin
        if (imem_rsp_valid) begin
          push    = 1'b1;
          state_d = S_REQ;
        end
      end
      S_FLUSH: begin
        if (imem_rsp_valid) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      push       = 1'b0;
      case (state_q)
        // An accepted request is still in flight and must be drained.
        S_REQ:          state_d = req_fire ? S_FLUSH : S_REQ;
        S_RSP, S_FLUSH: state_d = imem_rsp_valid ? S_REQ : S_FLUSH;
        default:        state_d = S_REQ;
      endcase
    end
  end

  // Fetch FSM and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  // FIFO pointer and occupancy update; a redirect empties the FIFO.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; entries are only read while counted, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data_q[wr_ptr_q] <= imem_rsp_data;
      buf_pc_q[wr_ptr_q]   <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized and directed stimulus for inst_fetch, checked each
// cycle against a transaction-level model (expected instruction queue plus a
// single-slot memory model).
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  unused_dbg_state;
`ifdef IFETCH_MISALIGN_CHK_EN
  logic        fetch_misalign;
`endif

  always #5 clk = ~clk;

  inst_fetch #(
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef IFETCH_MISALIGN_CHK_EN
    .fetch_misalign (fetch_misalign),
`endif
    .dbg_state_o    (unused_dbg_state)
  );

  // ---------------- reference model state ----------------
  logic [63:0] exp_q[$];      // {pc, word} expected at the FIFO head, in order
  logic [31:0] exp_pc;        // address of the next request
  logic        pend_valid;    // memory holds an accepted request
  logic        pend_live;     // its word should reach the FIFO
  logic [31:0] pend_addr;
  int          pend_wait;     // cycles until the memory answers
  logic        parked;
  logic        stale_rsp;     // drive a bogus response right after reset
  int          lat;           // latency given to the next accepted request
  int          n_cmp;
  int          n_mis;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0013 ^ (a << 3);
  endfunction

  function automatic logic model_req_v();
    return !pend_valid && (exp_q.size() < DEPTH) && !parked;
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic model_reset();
    exp_q.delete();
    exp_pc     = RST_PC;
    pend_valid = 1'b0;
    pend_live  = 1'b0;
    pend_addr  = '0;
    pend_wait  = 0;
    parked     = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst            = 1'b1;
      imem_req_ready = 1'($urandom_range(0, 1));
      inst_ready     = 1'($urandom_range(0, 1));
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
      imem_rsp_valid = 1'($urandom_range(0, 1));
      imem_rsp_data  = $urandom;
      #1;
      check_eq("req_valid_in_rst", {31'd0, imem_req_valid}, 32'd0);
      if (i > 0) begin
        check_eq("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check_eq("rst_inst", inst, NOP);
        check_eq("rst_inst_pc", inst_pc, 32'd0);
      end
    end
    model_reset();
    stale_rsp = 1'b1;
  endtask

  // One clock cycle: drive inputs, check outputs, advance the model to the edge.
  task automatic do_cycle(input logic rdy, input logic irdy, input logic redir,
                          input logic [31:0] rpc);
    logic        erv;
    logic        rsp;
    logic        hs;
    logic        pop;
    logic [31:0] data;
    @(negedge clk);
    rst            = 1'b0;
    imem_req_ready = rdy;
    inst_ready     = irdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    rsp  = pend_valid && (pend_wait == 0);
    data = mem_word(pend_addr);
    if (rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data;
    end else begin
      imem_rsp_valid = stale_rsp;
      imem_rsp_data  = $urandom;
    end
    stale_rsp = 1'b0;
    erv = model_req_v();
    #1;
    check_eq("req_valid", {31'd0, imem_req_valid}, {31'd0, erv});
    if (erv) check_eq("req_addr", imem_req_addr, exp_pc);
    check_eq("inst_valid", {31'd0, inst_valid}, {31'd0, (exp_q.size() != 0)});
    if (exp_q.size() != 0) begin
      check_eq("inst", inst, exp_q[0][31:0]);
      check_eq("inst_pc", inst_pc, exp_q[0][63:32]);
    end else begin
      check_eq("inst_empty", inst, NOP);
      check_eq("inst_pc_empty", inst_pc, 32'd0);
    end
`ifdef IFETCH_MISALIGN_CHK_EN
    check_eq("fetch_misalign", {31'd0, fetch_misalign}, {31'd0, parked});
`endif
    // model update for this edge
    hs  = erv && rdy;
    pop = (exp_q.size() != 0) && irdy && !redir;
    if (pop) void'(exp_q.pop_front());
    if (rsp) begin
      if (pend_live && !redir) exp_q.push_back({pend_addr, data});
      pend_valid = 1'b0;
    end else if (pend_valid) begin
      pend_wait--;
    end
    if (hs) begin
      pend_valid = 1'b1;
      pend_addr  = exp_pc;
      pend_live  = !redir;
      pend_wait  = lat - 1;
      exp_pc     = exp_pc + 32'd4;
    end
    if (redir) begin
      exp_q.delete();
      pend_live = 1'b0;
      exp_pc    = {rpc[31:2], 2'b00};
`ifdef IFETCH_MISALIGN_CHK_EN
      if (rpc[1:0] != 2'b00) parked = 1'b1;
`endif
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        found;
    logic [31:0] rpc;
    n_cmp          = 0;
    n_mis          = 0;
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stale_rsp      = 1'b0;
    lat            = 1;
    model_reset();

    // streaming with 1-cycle memory
    do_reset(2);
    lat = 1;
    repeat (16) do_cycle(1'b1, 1'b1, 1'b0, 32'd0);

    // downstream stall fills the buffer, then drains
    do_reset(2);
    repeat (10) do_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    repeat (10) do_cycle(1'b1, 1'b1, 1'b0, 32'd0);

    // memory not ready for 3 cycles
    do_reset(2);
    repeat (3) do_cycle(1'b0, 1'b1, 1'b0, 32'd0);
    repeat (8) do_cycle(1'b1, 1'b1, 1'b0, 32'd0);

    // redirect while waiting on the 0x104 response (3-cycle memory)
    do_reset(2);
    lat   = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (pend_valid && pend_live && pend_addr == RST_PC + 32'd4 && pend_wait > 0) found = 1'b1;
      else do_cycle(1'b1, 1'b0, 1'b0, 32'd0);
    end
    check_eq("reach_rsp_wait", {31'd0, found}, 32'd1);
    do_cycle(1'b1, 1'b0, 1'b1, 32'h0000_0200);
    lat = 1;
    repeat (10) do_cycle(1'b1, 1'b1, 1'b0, 32'd0);

    // redirect coinciding with a request handshake
    lat   = 2;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (model_req_v()) found = 1'b1;
      else do_cycle(1'b1, 1'b1, 1'b0, 32'd0);
    end
    check_eq("reach_req", {31'd0, found}, 32'd1);
    do_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0300);
    repeat (10) do_cycle(1'b1, 1'b1, 1'b0, 32'd0);

    // redirect coinciding with a response
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (pend_valid && pend_live && pend_wait == 0) found = 1'b1;
      else do_cycle(1'b1, 1'b1, 1'b0, 32'd0);
    end
    check_eq("reach_rsp", {31'd0, found}, 32'd1);
    do_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0400);
    lat = 1;
    repeat (10) do_cycle(1'b1, 1'b1, 1'b0, 32'd0);

    // PC wrap at the top of the address space
    do_cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (10) do_cycle(1'b1, 1'b1, 1'b0, 32'd0);

    // misaligned redirect target
    do_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0202);
    repeat (10) do_cycle(1'b1, 1'b1, 1'b0, 32'd0);

    // randomized traffic
    do_reset(1);
    for (int i = 0; i < 4000; i++) begin
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(1, 2));
      end else begin
        rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : $urandom;
`ifdef IFETCH_MISALIGN_CHK_EN
        if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
`endif
        do_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 11) == 0), rpc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
